// File: rtl/ureg_pkg.sv
// ureg_pkg: mode encoding shared by the universal register and its benches
package ureg_pkg;
    typedef logic [2:0] mode_t;
    localparam mode_t M_HOLD = 3'd0;
    localparam mode_t M_LOAD = 3'd1;
    localparam mode_t M_SHL  = 3'd2;
    localparam mode_t M_SHR  = 3'd3;
    localparam mode_t M_ROL  = 3'd4;
    localparam mode_t M_ROR  = 3'd5;
    localparam mode_t M_UP   = 3'd6;
    localparam mode_t M_DOWN = 3'd7;
endpackage

// File: rtl/ureg_cell.sv
// ureg_cell: one bit of the universal register with its mode mux
module ureg_cell
    import ureg_pkg::*;
(
    input  logic  c,
    input  logic  rn,
    input  logic  rv,
    input  logic  en,
    input  mode_t m,
    input  logic  d,
    input  logic  lo,
    input  logic  hi,
    input  logic  cu,
    input  logic  cd,
    output logic  q,
    output logic  qn
);
    logic nxt;
    // next value: lo feeds left moves, hi feeds right moves, cu/cd toggle for counting
    always_comb begin
        nxt = (m == M_LOAD) ? d :
              (m == M_SHL || m == M_ROL) ? lo :
              (m == M_SHR || m == M_ROR) ? hi :
              (m == M_UP) ? q ^ cu :
              (m == M_DOWN) ? q ^ cd : q;
    end
    // state flop; reset value arrives per bit from the parent
    always_ff @(posedge c or negedge rn) begin
        if (!rn) q <= rv;
        else if (en) q <= nxt;
    end
    assign qn = ~q;
endmodule

// File: rtl/ureg.sv
// ureg: W-bit universal register (load, shift, rotate, count) with complementary outputs
module ureg
    import ureg_pkg::*;
#(
    parameter int          W       = 8,
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic         c,
    input  logic         rn,
    input  logic         en,
    input  mode_t        m,
    input  logic [W-1:0] d,
    input  logic         si,
    output logic [W-1:0] q,
    output logic [W-1:0] qn,
    output logic         sol,
    output logic         sor,
    output logic         tc
);
    localparam logic [W-1:0] RV = RST_VAL[W-1:0];
    logic [W-1:0] lo, hi, cu, cd;
    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            if (i == 0) begin : g_lsb
                assign lo[i] = (m == M_ROL) ? q[W-1] : si;
                assign cu[i] = 1'b1;
                assign cd[i] = 1'b1;
            end else begin : g_mid_lo
                assign lo[i] = q[i-1];
                assign cu[i] = cu[i-1] & q[i-1];
                assign cd[i] = cd[i-1] & ~q[i-1];
            end
            if (i == W - 1) begin : g_msb
                assign hi[i] = (m == M_ROR) ? q[0] : si;
            end else begin : g_mid_hi
                assign hi[i] = q[i+1];
            end
            ureg_cell u_cell (
                .c(c), .rn(rn), .rv(RV[i]), .en(en), .m(m), .d(d[i]),
                .lo(lo[i]), .hi(hi[i]), .cu(cu[i]), .cd(cd[i]),
                .q(q[i]), .qn(qn[i])
            );
        end
    endgenerate
    assign sol = q[W-1];
    assign sor = q[0];
    assign tc  = rn & en & (((m == M_UP) & (&q)) | ((m == M_DOWN) & ~(|q)));
endmodule
